mm_adder_ctrl: RTL and testbench

- Tile-sequencing controller for the matrix adder datapath (mm_adder).
- On start, fetches all M_TILE x N_TILE tiles of matrix A, then all tiles of matrix B, from a tile buffer through a ready/request handshake, and drives the adder's in_valid, ptr_row and ptr_col for each tile.
- Then drains the M result rows, one per cycle, and pulses done.
- Sits between the tile buffer / top-level control and mm_adder.

---
 rtl/mm_adder_ctrl.sv | 150 +++++++++++++++
 tb/tb_mm_adder_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_adder_ctrl.sv
// Tile-sequencing controller for the mm_adder datapath.
// Streams every tile of A, then every tile of B, from the tile buffer into the
// adder in row-major tile order. It then drains the M result rows and pulses done.
//
// Handshake: in LOAD_A/LOAD_B, rd_req is high and rd_sel/rd_row/rd_col name the
// wanted tile. A tile is consumed in any cycle where rd_req and rd_ready are both
// high. add_in_valid mirrors that consume in the same cycle. When rd_ready is low,
// the request holds unchanged and there is no timeout. rd_ready is ignored in all
// other states.
module mm_adder_ctrl #(
  parameter int M      = 4,
  parameter int N      = 4,
  parameter int M_TILE = 2,
  parameter int N_TILE = 2,
  parameter int DW_INT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_req,
  output logic              rd_sel,
  output logic [DW_INT-1:0] rd_row,
  output logic [DW_INT-1:0] rd_col,
  input  logic              rd_ready,
  output logic              add_enable,
  output logic              add_in_valid,
  output logic [DW_INT-1:0] add_ptr_row,
  output logic [DW_INT-1:0] add_ptr_col,
  output logic              out_valid,
  output logic [DW_INT-1:0] out_row,
  output logic [2:0]        dbg_state
);

  // Tile counts per dimension; a partial edge tile still takes a slot.
  localparam int IT_M = (M + M_TILE - 1) / M_TILE;
  localparam int IT_N = (N + N_TILE - 1) / N_TILE;

  localparam logic [DW_INT-1:0] R_LAST     = DW_INT'(IT_M - 1);
  localparam logic [DW_INT-1:0] C_LAST     = DW_INT'(IT_N - 1);
  localparam logic [DW_INT-1:0] DRAIN_LAST = DW_INT'(M - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q;
  logic [DW_INT-1:0] r_q;
  logic [DW_INT-1:0] c_q;
  logic [DW_INT-1:0] drain_q;
  logic              out_valid_q;
  logic [DW_INT-1:0] out_row_q;

  logic in_load;
  logic in_drain;

  assign in_load  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign in_drain = (state_q == S_DRAIN);

  // Sequencer: state, tile counters, drain counter and the delayed row-valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      c_q         <= '0;
      drain_q     <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
    end else begin
      // Adder output for the row addressed this cycle appears one cycle later.
      out_valid_q <= in_drain;
      out_row_q   <= in_drain ? drain_q : '0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD_A;
            r_q     <= '0;
            c_q     <= '0;
            drain_q <= '0;
          end
        end

        S_LOAD_A, S_LOAD_B: begin
          if (rd_ready) begin
            if (c_q == C_LAST) begin
              c_q <= '0;
              if (r_q == R_LAST) begin
                r_q     <= '0;
                drain_q <= '0;
                state_q <= (state_q == S_LOAD_A) ? S_LOAD_B : S_DRAIN;
              end else begin
                r_q <= r_q + 1'b1;
              end
            end else begin
              c_q <= c_q + 1'b1;
            end
          end
        end

        S_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            drain_q <= '0;
            state_q <= S_DONE;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Buffer request and adder control decoded from state and counters.
  always_comb begin
    busy         = (state_q != S_IDLE);
    add_enable   = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    rd_req       = in_load;
    rd_sel       = (state_q == S_LOAD_B);
    rd_row       = in_load ? r_q : '0;
    rd_col       = in_load ? c_q : '0;
    add_in_valid = in_load && rd_ready;
    add_ptr_row  = '0;
    add_ptr_col  = '0;
    if (in_load) begin
      add_ptr_row = r_q;
      add_ptr_col = c_q;
    end else if (in_drain) begin
      add_ptr_row = drain_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mm_adder_ctrl.sv
// Bench for mm_adder_ctrl: two configurations (4x4 with 2x2 tiles, 6x6 with 4x4 tiles).
// The driver pushes the expected observable events, each stamped with its cycle.
// The monitor pops one event for every event the DUT presents and compares them.
module tb_mm_adder_ctrl;

  localparam logic [2:0] EV_TILE  = 3'd1;
  localparam logic [2:0] EV_STALL = 3'd2;
  localparam logic [2:0] EV_DRAIN = 3'd3;
  localparam logic [2:0] EV_OUT   = 3'd4;
  localparam logic [2:0] EV_DONE  = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    logic        sel;
    logic [7:0]  row;
    logic [7:0]  col;
    logic [31:0] cyc;
  } ev_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, rd_ready, cfg, mon_en;
  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  ev_t exp_q[$];
  logic [31:0] start_cyc, exp_lat;
  int cur_m, cur_itm, cur_itn;

  // ---------------- DUTs ----------------
  logic       b0_busy, b0_done, b0_rd_req, b0_rd_sel, b0_add_en, b0_aiv, b0_ov;
  logic [7:0] b0_rd_row, b0_rd_col, b0_apr, b0_apc, b0_or;
  logic [2:0] b0_st;
  logic       b1_busy, b1_done, b1_rd_req, b1_rd_sel, b1_add_en, b1_aiv, b1_ov;
  logic [7:0] b1_rd_row, b1_rd_col, b1_apr, b1_apc, b1_or;
  logic [2:0] b1_st;
  logic       start0, start1;

  assign start0 = start && (cfg == 1'b0);
  assign start1 = start && (cfg == 1'b1);

  mm_adder_ctrl #(.M(4), .N(4), .M_TILE(2), .N_TILE(2), .DW_INT(8)) dut (
    .clk(clk), .reset(reset), .start(start0), .busy(b0_busy), .done(b0_done),
    .rd_req(b0_rd_req), .rd_sel(b0_rd_sel), .rd_row(b0_rd_row), .rd_col(b0_rd_col),
    .rd_ready(rd_ready), .add_enable(b0_add_en), .add_in_valid(b0_aiv),
    .add_ptr_row(b0_apr), .add_ptr_col(b0_apc), .out_valid(b0_ov), .out_row(b0_or),
    .dbg_state(b0_st)
  );

  mm_adder_ctrl #(.M(6), .N(6), .M_TILE(4), .N_TILE(4), .DW_INT(8)) dut6 (
    .clk(clk), .reset(reset), .start(start1), .busy(b1_busy), .done(b1_done),
    .rd_req(b1_rd_req), .rd_sel(b1_rd_sel), .rd_row(b1_rd_row), .rd_col(b1_rd_col),
    .rd_ready(rd_ready), .add_enable(b1_add_en), .add_in_valid(b1_aiv),
    .add_ptr_row(b1_apr), .add_ptr_col(b1_apc), .out_valid(b1_ov), .out_row(b1_or),
    .dbg_state(b1_st)
  );

  // Observation point follows whichever configuration is under test.
  logic       m_busy, m_done, m_rd_req, m_rd_sel, m_add_en, m_aiv, m_ov;
  logic [7:0] m_rd_row, m_rd_col, m_apr, m_apc, m_or;
  always_comb begin
    m_busy   = cfg ? b1_busy   : b0_busy;
    m_done   = cfg ? b1_done   : b0_done;
    m_rd_req = cfg ? b1_rd_req : b0_rd_req;
    m_rd_sel = cfg ? b1_rd_sel : b0_rd_sel;
    m_add_en = cfg ? b1_add_en : b0_add_en;
    m_aiv    = cfg ? b1_aiv    : b0_aiv;
    m_ov     = cfg ? b1_ov     : b0_ov;
    m_rd_row = cfg ? b1_rd_row : b0_rd_row;
    m_rd_col = cfg ? b1_rd_col : b0_rd_col;
    m_apr    = cfg ? b1_apr    : b0_apr;
    m_apc    = cfg ? b1_apc    : b0_apc;
    m_or     = cfg ? b1_or     : b0_or;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic void push_ev(input logic [2:0] k, input logic s, input int r,
                                  input int c, input logic [31:0] cy);
    ev_t e;
    e.kind = k; e.sel = s; e.row = 8'(r); e.col = 8'(c); e.cyc = cy;
    exp_q.push_back(e);
  endfunction

  task automatic expect_ev(input logic [2:0] k, input logic s, input logic [7:0] r,
                           input logic [7:0] c);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_event: got kind=%0d row=%0d col=%0d want none (cycle %0d)",
               k, r, c, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", 32'(k), 32'(e.kind));
      chk("ev_cycle", cyc, e.cyc);
      chk("ev_sel", 32'(s), 32'(e.sel));
      chk("ev_row", 32'(r), 32'(e.row));
      chk("ev_col", 32'(c), 32'(e.col));
      if (e.kind == EV_TILE || e.kind == EV_STALL) begin
        chk("add_ptr_row", 32'(m_apr), 32'(e.row));
        chk("add_ptr_col", 32'(m_apc), 32'(e.col));
      end
      if (e.kind == EV_DONE) chk("done_latency", cyc - start_cyc, exp_lat);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("add_enable", 32'(m_add_en), 32'(m_busy));
      if (!m_busy) begin
        chk("idle_rd_req", 32'(m_rd_req), 0);
        chk("idle_in_valid", 32'(m_aiv), 0);
        chk("idle_out_valid", 32'(m_ov), 0);
        chk("idle_done", 32'(m_done), 0);
      end else begin
        if (m_rd_req)
          expect_ev(m_aiv ? EV_TILE : EV_STALL, m_rd_sel, m_rd_row, m_rd_col);
        else if (!m_done) begin
          chk("drain_in_valid", 32'(m_aiv), 0);
          expect_ev(EV_DRAIN, 1'b0, m_apr, m_apc);
        end
        if (m_ov) expect_ev(EV_OUT, 1'b0, m_or, 8'd0);
        if (m_done) expect_ev(EV_DONE, 1'b0, 8'd0, 8'd0);
      end
    end
  end

  // ---------------- driver / reference model ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // mode: 0 = rd_ready always high, 1 = three stall cycles on A tile (0,1),
  // 2 = random stalls. abort: reset while B tile (1,0) is requested.
  task automatic run_op(input int mode, input bit abort);
    int tiles, consumed, stalls, fixed_stalls, guard;
    logic rdy;
    tiles = cur_itm * cur_itn;
    step();
    start = 1'b1; rd_ready = 1'($urandom_range(1));
    start_cyc = cyc;
    step();
    consumed = 0; stalls = 0; fixed_stalls = 0; guard = 0;
    while (consumed < 2 * tiles) begin
      int idx;
      logic s;
      s   = (consumed >= tiles);
      idx = consumed % tiles;
      rdy = 1'b1;
      if (mode == 1 && consumed == 1 && fixed_stalls < 3) begin
        rdy = 1'b0; fixed_stalls++;
      end
      if (mode == 2) rdy = ($urandom_range(99) >= 35);
      start = 1'($urandom_range(1));
      if (abort && consumed == tiles + cur_itn) begin
        push_ev(EV_STALL, 1'b1, idx / cur_itn, idx % cur_itn, cyc);
        reset = 1'b1; rd_ready = 1'b0; start = 1'b0;
        step();
        reset = 1'b0;
        return;
      end
      push_ev(rdy ? EV_TILE : EV_STALL, s, idx / cur_itn, idx % cur_itn, cyc);
      rd_ready = rdy;
      if (rdy) consumed++; else stalls++;
      guard++;
      if (guard > 2000) begin
        total++; bad++;
        $display("FAIL load_budget: got=%0d cycles want<=2000", guard);
        return;
      end
      step();
    end
    exp_lat = 32'(2 * tiles + stalls + cur_m + 1);
    for (int k = 0; k <= cur_m; k++) begin
      if (k < cur_m) push_ev(EV_DRAIN, 1'b0, k, 0, cyc);
      if (k > 0)     push_ev(EV_OUT, 1'b0, k - 1, 0, cyc);
      if (k == cur_m) push_ev(EV_DONE, 1'b0, 0, 0, cyc);
      start    = 1'($urandom_range(1));
      rd_ready = 1'($urandom_range(1));
      step();
    end
    start = 1'b0;
  endtask

  task automatic drain_check(input string nm);
    step(); step();
    chk(nm, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic set_cfg(input logic c);
    cfg = c;
    cur_m   = c ? 6 : 4;
    cur_itm = c ? (6 + 3) / 4 : (4 + 1) / 2;
    cur_itn = cur_itm;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rd_ready = 1'b0; mon_en = 1'b0;
    start_cyc = 0; exp_lat = 0;
    set_cfg(1'b0);
    repeat (3) step();
    reset = 1'b0; mon_en = 1'b1;
    // idle with rd_ready high and no start: monitor checks quiet outputs
    rd_ready = 1'b1;
    repeat (5) step();

    run_op(0, 1'b0); drain_check("q_empty_basic");
    run_op(1, 1'b0); drain_check("q_empty_backpressure");
    repeat (3) begin
      run_op(2, 1'b0); drain_check("q_empty_random");
    end
    run_op(0, 1'b1); drain_check("q_empty_abort");
    run_op(0, 1'b0); drain_check("q_empty_after_abort");

    set_cfg(1'b1);
    step();
    run_op(0, 1'b0); drain_check("q_empty_cfg6");
    run_op(2, 1'b0); drain_check("q_empty_cfg6_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
